// File: rtl/load_store_unit.sv
// Load/store unit: aligns, splits and extends byte/half/word accesses
// against a word-wide synchronous-read memory port.
package lsu_pkg;
  typedef enum logic [3:0] {
    LOAD_BYTE, LOAD_HALF, LOAD_WORD,
    ULOAD_BYTE, ULOAD_HALF,
    STORE_BYTE, STORE_HALF, STORE_WORD
  } InstructionSubTypes;

  typedef struct packed {
    logic [2:0] size;
    logic       ld;
    logic       st;
    logic       sgn;
  } acc_t;

  function automatic acc_t decode(InstructionSubTypes t);
    acc_t a;
    a = '0;
    unique case (t)
      LOAD_BYTE:  a = '{3'd1, 1'b1, 1'b0, 1'b1};
      LOAD_HALF:  a = '{3'd2, 1'b1, 1'b0, 1'b1};
      LOAD_WORD:  a = '{3'd4, 1'b1, 1'b0, 1'b1};
      ULOAD_BYTE: a = '{3'd1, 1'b1, 1'b0, 1'b0};
      ULOAD_HALF: a = '{3'd2, 1'b1, 1'b0, 1'b0};
      STORE_BYTE: a = '{3'd1, 1'b0, 1'b1, 1'b0};
      STORE_HALF: a = '{3'd2, 1'b0, 1'b1, 1'b0};
      STORE_WORD: a = '{3'd4, 1'b0, 1'b1, 1'b0};
      default:    a = '0;
    endcase
    return a;
  endfunction
endpackage

module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic               iReqValid,
  output logic               oReqReady,
  input  InstructionSubTypes iMemoryInstructionType,
  input  logic [31:0]        iAddress,
  input  logic [31:0]        iStoreData,
  output logic               oRespValid,
  output logic [31:0]        oLoadData,
  output logic               oMisaligned,
  output logic [31:0]        oMemAddress,
  output logic               oMemWriteEn,
  output logic [3:0]         oMemByteEn,
  output logic [31:0]        oMemWriteData,
  input  logic [31:0]        iMemReadData
);
  typedef enum logic [2:0] {
    IDLE, ACC0, ACC1, DONE, ERR
  } state_t;

  state_t      state, state_n;
  acc_t        req, acc_q;
  logic        req_split, split_q;
  logic [31:0] addr_q, data_q, lo_q;
  logic [1:0]  off;
  logic [31:0] word_a;
  logic [7:0]  lanes;
  logic [63:0] wide, pair;
  logic [31:0] shifted, load_ext;

  assign req = decode(iMemoryInstructionType);
  assign req_split = (req.ld | req.st) &&
    (({2'b00, iAddress[1:0]} + {1'b0, req.size}) > 4'd4);

  assign off     = addr_q[1:0];
  assign word_a  = {addr_q[31:2], 2'b00};
  // lane mask and data span two words; upper half feeds the second access
  assign lanes   = ((8'd1 << acc_q.size) - 8'd1) << off;
  assign wide    = {32'd0, data_q} << {off, 3'b000};
  assign pair    = split_q ? {iMemReadData, lo_q}
                           : {32'd0, iMemReadData};
  assign shifted = 32'(pair >> {off, 3'b000});

  always_comb begin
    load_ext = shifted;
    unique case (acc_q.size)
      3'd1: load_ext = {{24{acc_q.sgn & shifted[7]}}, shifted[7:0]};
      3'd2: load_ext = {{16{acc_q.sgn & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      addr_q  <= '0;
      data_q  <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      split_q <= 1'b0;
    end else begin
      if (state == IDLE && iReqValid) begin
        addr_q  <= iAddress;
        data_q  <= iStoreData;
        acc_q   <= req;
        split_q <= req_split;
      end
      if (state == ACC1) lo_q <= iMemReadData;
    end
  end

  always_comb begin
    state_n       = state;
    oReqReady     = 1'b0;
    oRespValid    = 1'b0;
    oLoadData     = '0;
    oMisaligned   = 1'b0;
    oMemAddress   = '0;
    oMemWriteEn   = 1'b0;
    oMemByteEn    = '0;
    oMemWriteData = '0;
    unique case (state)
      IDLE: begin
        oReqReady = 1'b1;
        if (iReqValid)
          state_n = (req_split && !ALLOW_MISALIGNED) ? ERR : ACC0;
      end
      ACC0: begin
        if (acc_q.ld | acc_q.st) oMemAddress = word_a;
        if (acc_q.st) begin
          oMemWriteEn   = 1'b1;
          oMemByteEn    = lanes[3:0];
          oMemWriteData = wide[31:0];
        end
        state_n = split_q ? ACC1 : DONE;
      end
      ACC1: begin
        oMemAddress = word_a + 32'd4;
        if (acc_q.st) begin
          oMemWriteEn   = 1'b1;
          oMemByteEn    = lanes[7:4];
          oMemWriteData = wide[63:32];
        end
        state_n = DONE;
      end
      DONE: begin
        oRespValid = 1'b1;
        if (acc_q.ld) oLoadData = load_ext;
        state_n = IDLE;
      end
      ERR: begin
        oRespValid  = 1'b1;
        oMisaligned = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic
// checked against a byte-addressed reference memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic valid, valid0;
  InstructionSubTypes typ;
  logic [31:0] addr, sdata;

  logic ready, resp, mis, mwe;
  logic [31:0] load, maddr, mwd, rd;
  logic [3:0] mbe;

  logic ready0, resp0, mis0, mwe0;
  logic [31:0] load0, maddr0, mwd0, rd0;
  logic [3:0] mbe0;

  logic pl_en;
  logic [31:0] pl_addr, pl_data;
  logic [31:0] env_mem [0:255];
  logic [7:0] ref_mem [0:1023];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .iClk(clk), .iRstN(rst_n),
    .iReqValid(valid), .oReqReady(ready),
    .iMemoryInstructionType(typ),
    .iAddress(addr), .iStoreData(sdata),
    .oRespValid(resp), .oLoadData(load),
    .oMisaligned(mis), .oMemAddress(maddr),
    .oMemWriteEn(mwe), .oMemByteEn(mbe),
    .oMemWriteData(mwd), .iMemReadData(rd)
  );

  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut0 (
    .iClk(clk), .iRstN(rst_n),
    .iReqValid(valid0), .oReqReady(ready0),
    .iMemoryInstructionType(typ),
    .iAddress(addr), .iStoreData(sdata),
    .oRespValid(resp0), .oLoadData(load0),
    .oMisaligned(mis0), .oMemAddress(maddr0),
    .oMemWriteEn(mwe0), .oMemByteEn(mbe0),
    .oMemWriteData(mwd0), .iMemReadData(rd0)
  );

  // word memory with synchronous read seen by the main instance
  always @(posedge clk) begin
    if (pl_en)
      env_mem[pl_addr[9:2]] <= pl_data;
    else if (mwe)
      for (int k = 0; k < 4; k++)
        if (mbe[k])
          env_mem[maddr[9:2]][8*k +: 8] <= mwd[8*k +: 8];
    rd <= env_mem[maddr[9:2]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic void spec_kind(input InstructionSubTypes t,
      output int sz, output bit ld, output bit st, output bit sgn);
    sz = 0; ld = 0; st = 0; sgn = 0;
    case (t)
      LOAD_BYTE:  begin sz = 1; ld = 1; sgn = 1; end
      LOAD_HALF:  begin sz = 2; ld = 1; sgn = 1; end
      LOAD_WORD:  begin sz = 4; ld = 1; sgn = 1; end
      ULOAD_BYTE: begin sz = 1; ld = 1; end
      ULOAD_HALF: begin sz = 2; ld = 1; end
      STORE_BYTE: begin sz = 1; st = 1; end
      STORE_HALF: begin sz = 2; st = 1; end
      STORE_WORD: begin sz = 4; st = 1; end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int sz,
                                           input bit sgn);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[a + i];
    if (sgn && sz < 4 && v[8*sz - 1])
      for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = w;
    @(posedge clk);
    #1 pl_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[int'(a & ~32'd3) + i] = w[8*i +: 8];
  endtask

  task automatic run_req(input InstructionSubTypes t, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] obs);
    int sz, o;
    bit ld, st, sgn, split;
    logic [3:0] be1, be2;
    logic [31:0] base, exp_ld;
    spec_kind(t, sz, ld, st, sgn);
    o = int'(a[1:0]);
    split = (ld || st) && (o + sz > 4);
    base = a & ~32'd3;
    for (int k = 0; k < 4; k++) begin
      be1[k] = (k >= o) && (k <= o + sz - 1);
      be2[k] = (k <= o + sz - 5);
    end
    exp_ld = ld ? ref_load(int'(a), sz, sgn) : 32'd0;
    @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);
    valid = 1'b1; typ = t; addr = a; sdata = d;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    chk("acc0_resp", 32'(resp), 32'd0);
    chk("acc0_ready", 32'(ready), 32'd0);
    chk("acc0_we", 32'(mwe), 32'(st));
    chk("acc0_be", 32'(mbe), st ? 32'(be1) : 32'd0);
    if (ld || st) chk("acc0_addr", maddr, base);
    if (st) chk("acc0_wd", mwd, d << (8*o));
    if (split) begin
      @(negedge clk);
      chk("acc1_resp", 32'(resp), 32'd0);
      chk("acc1_addr", maddr, base + 32'd4);
      chk("acc1_we", 32'(mwe), 32'(st));
      chk("acc1_be", 32'(mbe), st ? 32'(be2) : 32'd0);
      if (st) chk("acc1_wd", mwd, d >> (8*(4 - o)));
    end
    @(negedge clk);
    chk("done_resp", 32'(resp), 32'd1);
    chk("done_mis", 32'(mis), 32'd0);
    chk("done_load", load, exp_ld);
    chk("done_we", 32'(mwe), 32'd0);
    obs = load;
    if (st)
      for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
    @(negedge clk);
    chk("post_resp", 32'(resp), 32'd0);
    chk("post_ready", 32'(ready), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_resp"}, 32'(resp), 32'd0);
    chk({tag, "_load"}, load, 32'd0);
    chk({tag, "_mis"}, 32'(mis), 32'd0);
    chk({tag, "_maddr"}, maddr, 32'd0);
    chk({tag, "_we"}, 32'(mwe), 32'd0);
    chk({tag, "_be"}, 32'(mbe), 32'd0);
    chk({tag, "_wd"}, mwd, 32'd0);
  endtask

  initial begin
    logic [31:0] obs;
    int bad;
    rst_n = 1'b0; valid = 1'b0; valid0 = 1'b0;
    typ = LOAD_WORD; addr = '0; sdata = '0; rd0 = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    #1 chk_reset_outs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int w = 0; w < 256; w++) preload(32'(w * 4), $urandom);

    run_req(STORE_WORD, 32'h100, 32'hDEADBEEF, obs);
    chk("sw_mem", env_mem[32'h100 >> 2], 32'hDEADBEEF);

    preload(32'h100, 32'h80FF1234);
    run_req(LOAD_BYTE, 32'h103, 32'h0, obs);
    chk("lb_103", obs, 32'hFFFFFF80);
    run_req(ULOAD_BYTE, 32'h103, 32'h0, obs);
    chk("lbu_103", obs, 32'h00000080);
    run_req(LOAD_HALF, 32'h102, 32'h0, obs);
    chk("lh_102", obs, 32'hFFFF80FF);

    preload(32'h100, 32'h44332211);
    preload(32'h104, 32'h88776655);
    run_req(LOAD_WORD, 32'h102, 32'h0, obs);
    chk("lw_102", obs, 32'h66554433);

    run_req(STORE_HALF, 32'h107, 32'h0000ABCD, obs);
    chk("sh_lo_mem", env_mem[32'h104 >> 2], 32'hCD776655);
    chk("sh_hi_mem", 32'(env_mem[32'h108 >> 2][7:0]), 32'hAB);

    // repeat the split store and abort it in its second cycle
    preload(32'h108, 32'h5A5A5A5A);
    @(negedge clk);
    valid = 1'b1; typ = STORE_HALF; addr = 32'h107; sdata = 32'hABCD;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    chk("rpt_acc0_we", 32'(mwe), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midrst");
    @(negedge clk);
    chk("rst_resp", 32'(resp), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_noresp", 32'(resp), 32'd0);
    end
    chk("abort_nowrite", env_mem[32'h108 >> 2], 32'h5A5A5A5A);

    @(negedge clk);
    valid0 = 1'b1; typ = LOAD_WORD; addr = 32'h101;
    @(posedge clk);
    #1 valid0 = 1'b0;
    @(negedge clk);
    chk("err_resp", 32'(resp0), 32'd1);
    chk("err_mis", 32'(mis0), 32'd1);
    chk("err_load", load0, 32'd0);
    chk("err_we", 32'(mwe0), 32'd0);
    chk("err_be", 32'(mbe0), 32'd0);
    @(negedge clk);
    chk("err_ready", 32'(ready0), 32'd1);
    chk("err_noresp", 32'(resp0), 32'd0);

    for (int n = 0; n < 200; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r > 7) r = int'($urandom_range(8, 15));
      run_req(InstructionSubTypes'(4'(r)), 32'($urandom_range(0, 1015)),
              $urandom, obs);
    end

    bad = 0;
    for (int w = 0; w < 256; w++)
      for (int i = 0; i < 4; i++)
        if (env_mem[w][8*i +: 8] !== ref_mem[4*w + i]) bad++;
    chk("mem_sweep", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
